borrow_lookahead_sub: RTL and testbench
=======================================

# borrow_lookahead_sub

Two-stage pipelined subtractor computing `a - b - b_in` with group borrow-lookahead. It is the subtraction counterpart of the team's carry-lookahead adder path. Borrow generate/propagate replaces carry generate/propagate, and 4-bit lookahead groups are combined by a second lookahead level. The block sits between a producer and a consumer, each using a valid/ready handshake. It sustains one operation per cycle and holds data correctly under backpressure.

## Interface
- `WIDTH`, default 16: operand width; must be a multiple of 4, range 4..64.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: reset, asynchronous and active-high.
- `in_valid` input 1: operand set presented.
- `in_ready` output 1: block accepts operands this cycle.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `b_in` input 1: borrow in.
- `out_valid` output 1: result presented.
- `out_ready` input 1: consumer accepts result this cycle.
- `diff` output WIDTH: `(a - b - b_in) mod 2^WIDTH`.
- `b_out` output 1: borrow out; 1 iff unsigned `a < b + b_in`.
- `ovf` output 1: two's-complement overflow.
- `zero` output 1: `diff == 0`.

## Operation
- Bit level:
  - borrow generate `g_i = ~a_i & b_i`
  - borrow propagate `p_i = ~(a_i ^ b_i)`
  - `diff_i = a_i ^ b_i ^ br_i`
  - `br_{i+1} = g_i | (p_i & br_i)`
  - `br_0 = b_in`
- Group level (4 bits each):
  - `G = g3 | p3g2 | p3p2g1 | p3p2p1g0`
  - `P = p3p2p1p0`
  - Group borrows come from a second lookahead over (G, P) seeded with `b_in`.
  - No ripple across groups.
- Stage 1 (S1) registers:
  - `a ^ b`
  - per-bit g/p
  - per-group G/P
  - `b_in`
  - sign bits `a[W-1]` and `b[W-1]`
- Stage 2 (S2) registers `diff`, `b_out`, `ovf` and `zero`, computed from the S1 registers.
- Flag definitions:
  - `b_out` = final group-level borrow.
  - `ovf = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1])`.
  - `zero = ~|diff`.
- Pipeline control (two valid bits, `v1` and `v2`; no other state machine):
  - S2 loads when `~v2 | out_ready`.
  - `s1_adv = v1 & (~v2 | out_ready)`.
  - S1 loads when `~v1 | s1_adv`.
  - `in_ready = ~v1 | (~v2 | out_ready)`. It is combinational and never depends on `in_valid`.
  - Accept = `in_valid & in_ready`; `v1` becomes 1 on accept, else 0 if S1 advances.
  - `v2` becomes 1 when S1 advances, else 0 when `out_ready`.
  - `out_valid = v2`.
  - Data registers load only on their stage's load enable. Held values are otherwise stable.
- Reset:
  - `v1`, `v2`, `diff`, `b_out`, `ovf`, `zero` clear to 0.
  - `out_valid` = 0 and `in_ready` = 1 while `rst` is high.
  - S1 data registers clear to 0.
- Reset mid-operation discards in-flight operations. No result is emitted for them after reset deasserts.

## Timing
- Latency: accept on edge N gives `out_valid`=1 with the result after edge N+2 (visible in cycle N+2).
- Throughput: 1 result/cycle while `out_ready`=1.
- Output stability: while `out_valid & ~out_ready`, `diff`/`b_out`/`ovf`/`zero` are held constant.
- Stall sequence with `out_ready`=0 and `in_valid`=1:
  - 2 operations fill S1 and S2.
  - `in_ready` falls in the cycle after the second accept.
  - `in_ready` rises in the same cycle that `out_ready` is seen high (pass-through ready).
- Simultaneous accept and S1 advance: S1 reloads with the new operand and S2 takes the old one. Nothing is lost or duplicated.
- Ordering: results emerge strictly in acceptance order.
- Combinational depth per stage is bounded by one group-lookahead level. There is no WIDTH-length ripple.

## Test plan
- Basic subtract: `a`=0x0005, `b`=0x0003, `b_in`=0 → `diff`=0x0002, `b_out`=0, `ovf`=0, `zero`=0, exactly 2 cycles after accept.
- Unsigned wrap: `a`=0x0000, `b`=0x0001, `b_in`=0 → `diff`=0xFFFF, `b_out`=1, `ovf`=0. Cross-group borrow case: `a`=0x1000, `b`=0x0001 → `diff`=0x0FFF, `b_out`=0.
- Signed overflow: `a`=0x8000, `b`=0x0001 → `diff`=0x7FFF, `ovf`=1, `b_out`=0. `a`=0x7FFF, `b`=0xFFFF → `diff`=0x8000, `ovf`=1, `b_out`=1.
- Borrow-in and zero: `a`=0x1234, `b`=0x1233, `b_in`=1 → `diff`=0x0000, `zero`=1, `b_out`=0.
- Backpressure: stream operands 1..6 (each `a`=k, `b`=0) with `out_ready` low for cycles 3-5.
  - `in_ready` is 0 while both stages are full.
  - Outputs are held stable while stalled.
  - Results 1..6 emerge in order with none dropped or repeated.
  - After release, throughput returns to 1/cycle.
- Reset mid-flight: two operations in the pipe, pulse `rst` asynchronously between edges.
  - `out_valid` drops to 0 immediately and `in_ready`=1.
  - No stale result appears within 5 cycles after release.
  - A new operation `a`=9, `b`=4 yields `diff`=5 after 2 cycles.
  - Random regression: 10k random operands with random `in_valid`/`out_ready`, compared against a `{1'b0,a} - b - b_in` reference model.

Source files
------------

// File: rtl/borrow_lookahead_sub.sv
// Two-stage valid/ready pipelined subtractor: diff = a - b - b_in, using bit-level
// borrow generate/propagate, 4-bit lookahead groups and a second lookahead level across groups.
`timescale 1ns/1ps
module borrow_lookahead_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf,
    output logic             zero
);
    localparam int NG = WIDTH / 4;

    // Borrow into position n, expanded as a flat sum of products so no term chains
    // through a lower position's result.
    function automatic logic lookahead_grp(input logic [NG-1:0] gv, input logic [NG-1:0] pv,
                                           input logic seed, input int n);
        logic res;
        logic t;
        res = seed;
        for (int m = 0; m < n; m++) res = res & pv[m];
        for (int k = 0; k < n; k++) begin
            t = gv[k];
            for (int m = k + 1; m < n; m++) t = t & pv[m];
            res = res | t;
        end
        return res;
    endfunction

    function automatic logic lookahead_bit(input logic [3:0] gv, input logic [3:0] pv,
                                           input logic seed, input int n);
        logic res;
        logic t;
        res = seed;
        for (int m = 0; m < n; m++) res = res & pv[m];
        for (int k = 0; k < n; k++) begin
            t = gv[k];
            for (int m = k + 1; m < n; m++) t = t & pv[m];
            res = res | t;
        end
        return res;
    endfunction

    logic             v1;
    logic             v2;
    logic             s2_ld;
    logic             s1_adv;
    logic             accept;

    logic [WIDTH-1:0] x_c;
    logic [WIDTH-1:0] g_c;
    logic [WIDTH-1:0] p_c;
    logic [NG-1:0]    gg_c;
    logic [NG-1:0]    gp_c;

    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] g_r;
    logic [WIDTH-1:0] p_r;
    logic [NG-1:0]    gg_r;
    logic [NG-1:0]    gp_r;
    logic             bin_r;
    logic             sa_r;
    logic             sb_r;

    logic [NG:0]      gb;
    logic [WIDTH-1:0] br;
    logic [WIDTH-1:0] diff_c;
    logic             ovf_c;

    assign s2_ld     = ~v2 | out_ready;
    assign s1_adv    = v1 & s2_ld;
    assign in_ready  = ~v1 | s2_ld;
    assign accept    = in_valid & in_ready;
    assign out_valid = v2;

    always_comb begin
        x_c  = a ^ b;
        g_c  = ~a & b;
        p_c  = ~(a ^ b);
        gg_c = '0;
        gp_c = '0;
        for (int j = 0; j < NG; j++) begin
            gg_c[j] = g_c[4*j+3]
                    | (p_c[4*j+3] & g_c[4*j+2])
                    | (p_c[4*j+3] & p_c[4*j+2] & g_c[4*j+1])
                    | (p_c[4*j+3] & p_c[4*j+2] & p_c[4*j+1] & g_c[4*j]);
            gp_c[j] = &p_c[4*j +: 4];
        end
    end

    always_comb begin
        gb = '0;
        br = '0;
        for (int j = 0; j <= NG; j++) gb[j] = lookahead_grp(gg_r, gp_r, bin_r, j);
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < 4; i++) begin
                br[4*j+i] = lookahead_bit(g_r[4*j +: 4], p_r[4*j +: 4], gb[j], i);
            end
        end
        diff_c = x_r ^ br;
        ovf_c  = (sa_r != sb_r) & (diff_c[WIDTH-1] != sa_r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (accept)      v1 <= 1'b1;
            else if (s1_adv) v1 <= 1'b0;
            if (s1_adv)         v2 <= 1'b1;
            else if (out_ready) v2 <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r   <= '0;
            g_r   <= '0;
            p_r   <= '0;
            gg_r  <= '0;
            gp_r  <= '0;
            bin_r <= 1'b0;
            sa_r  <= 1'b0;
            sb_r  <= 1'b0;
        end else if (accept) begin
            x_r   <= x_c;
            g_r   <= g_c;
            p_r   <= p_c;
            gg_r  <= gg_c;
            gp_r  <= gp_c;
            bin_r <= b_in;
            sa_r  <= a[WIDTH-1];
            sb_r  <= b[WIDTH-1];
        end
    end

    // Outputs only change when a new result moves in, so they hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff  <= '0;
            b_out <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (s1_adv) begin
            diff  <= diff_c;
            b_out <= gb[NG];
            ovf   <= ovf_c;
            zero  <= ~|diff_c;
        end
    end
endmodule

// File: tb/tb_borrow_lookahead_sub.sv
// Bench for borrow_lookahead_sub: directed vector table, backpressure and reset
// sequences, then a random handshake regression against a reference model.
`timescale 1ns/1ps
module tb_borrow_lookahead_sub;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        b_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        b_out;
    logic        ovf;
    logic        zero;

    int n_cmp = 0;
    int n_bad = 0;

    borrow_lookahead_sub #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .b_out(b_out), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input int i);
        int lat;
        bit found;
        @(negedge clk);
        a = vt[i].a; b = vt[i].b; b_in = vt[i].bi;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 chk("vec_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; found = 0;
        while (!found && lat < 6) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) found = 1;
        end
        chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        if (found) begin
            chk($sformatf("vec%0d_diff", i), 32'(diff), 32'(vt[i].d));
            chk($sformatf("vec%0d_b_out", i), 32'(b_out), 32'(vt[i].bo));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vt[i].ov));
            chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vt[i].z));
        end
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] exp_ir;
        logic [11:0] exp_ov;
        logic [15:0] exp_d[12];
        logic [18:0] q[$];
        logic [18:0] held_v;
        logic [18:0] m;
        logic [16:0] full;
        bit          held;
        int          k;
        int          sent;
        int          got;
        int          cyc;

        vt[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        vt[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vt[2] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vt[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vt[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vt[5] = '{16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vt[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vt[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vt[8] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
        vt[9] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; b_in = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_diff", 32'(diff), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_flags", 32'({b_out, ovf, zero}), 32'd0);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Backpressure: out_ready low in stream cycles 3..5.
        exp_ir = 12'b1111_1110_0011;
        exp_ov = 12'b0111_1111_1100;
        exp_d  = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd0};
        k = 1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (k <= 6);
            a = 16'(k); b = 16'd0; b_in = 1'b0;
            #1;
            chk($sformatf("bp_c%0d_in_ready", c), 32'(in_ready), 32'(exp_ir[c-1]));
            chk($sformatf("bp_c%0d_out_valid", c), 32'(out_valid), 32'(exp_ov[c-1]));
            if (exp_ov[c-1]) chk($sformatf("bp_c%0d_diff", c), 32'(diff), 32'(exp_d[c-1]));
            if (in_valid && in_ready) k++;
        end
        chk("bp_accepted", 32'(k), 32'd7);
        in_valid = 1'b0;

        // Reset with two operations in flight.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 16'd1; b = 16'd0; b_in = 1'b0;
        @(negedge clk);
        a = 16'd2;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1 chk($sformatf("post_rst_c%0d_out_valid", c), 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        a = 16'd9; b = 16'd4; b_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_lat1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_diff", 32'(diff), 32'd5);
        chk("post_rst_b_out", 32'(b_out), 32'd0);

        // Random regression with random handshakes.
        sent = 0; got = 0; cyc = 0; held = 0; held_v = '0;
        while (got < 10000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            b_in      = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (held) chk("rand_hold", 32'({out_valid, diff, b_out, ovf, zero}), 32'({1'b1, held_v}));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    m = q.pop_front();
                    chk("rand_result", 32'({diff, b_out, ovf, zero}), 32'(m));
                end
                got++;
            end
            held   = out_valid && !out_ready;
            held_v = {diff, b_out, ovf, zero};
            if (in_valid && in_ready) begin
                full = {1'b0, a} - {1'b0, b} - {16'd0, b_in};
                m = {full[15:0], full[16],
                     (a[15] != b[15]) && (full[15] != a[15]),
                     full[15:0] == 16'd0};
                q.push_back(m);
                sent++;
            end
        end
        chk("rand_results_seen", 32'(got), 32'd10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
